i2c_byte_capture: RTL

I2C_BYTE_CAPTURE -- requirements
Module: i2c_byte_capture

---
 rtl/i2c_byte_capture.sv | 342 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_capture.sv
// rtl/i2c_byte_capture.sv - passive I2C byte capture into a first-word-fall-through record FIFO
//
// Taps SCL/SDA (plus the repeater's SDA direction), filters the lines, detects
// START/STOP, assembles 8 data bits plus the ACK bit and queues one record per byte.
//
// Parameters:
//   FILTER_LEN  consecutive equal synchronised samples needed to flip a filtered line (2..16)
//   FIFO_DEPTH  record FIFO entries, power of two (2..64)
//
// Ports:
//   system_clk   block clock, rising edge
//   reset        asynchronous, active-high
//   scl_in       tapped SCL (asynchronous)
//   sda_in       tapped SDA (asynchronous)
//   dir_in       SDA direction, 0 = master drives, 1 = slave drives (asynchronous)
//   out_valid    head record present on out_*
//   out_ready    consumer accepts the head record when out_valid & out_ready
//   out_data     captured byte
//   out_ack      1 = ACK, 0 = NACK
//   out_start    byte was the first after START / repeated START
//   out_dir      dir_in latched at the byte's first bit
//   bus_busy     high from START to STOP
//   abort_pulse  one-cycle pulse when START/STOP truncates a partial byte
//   overflow     sticky, a record was dropped on a full FIFO
//   clr_ovf      synchronous clear of overflow (a same-cycle set wins)
//   out_ts       (I2C_BYTE_CAPTURE_TIMESTAMP_EN only) 16-bit cycle stamp of the head record
//
// Build option: define I2C_BYTE_CAPTURE_TIMESTAMP_EN to add the per-record cycle timestamp.

module i2c_byte_capture #(
    parameter int FILTER_LEN = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    input  logic        dir_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_ack,
    output logic        out_start,
    output logic        out_dir,
    output logic        bus_busy,
    output logic        abort_pulse,
    output logic        overflow,
    input  logic        clr_ovf
`ifdef I2C_BYTE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [15:0] out_ts
`endif
);

    localparam int FCW = $clog2(FILTER_LEN);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CORE_W = 11;
`ifdef I2C_BYTE_CAPTURE_TIMESTAMP_EN
    localparam int REC_W = CORE_W + 16;
`else
    localparam int REC_W = CORE_W;
`endif
    localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [AW:0]    DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronisers; all reset to 1 so the bus looks idle.
    // ------------------------------------------------------------------
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic [1:0] dir_sync;
    logic       scl_s;
    logic       sda_s;
    logic       dir_s;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            dir_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            dir_sync <= {dir_sync[0], dir_in};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
    assign dir_s = dir_sync[1];

    // ------------------------------------------------------------------
    // Glitch filters: the counter tracks how many consecutive samples have
    // disagreed with the filtered value; FILTER_LEN of them flip the line.
    // ------------------------------------------------------------------
    logic           scl_f;
    logic           sda_f;
    logic [FCW-1:0] scl_cnt;
    logic [FCW-1:0] sda_cnt;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FCNT_MAX) begin
                scl_f   <= scl_s;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end

            if (sda_s == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FCNT_MAX) begin
                sda_f   <= sda_s;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus condition detection on the filtered lines.
    // ------------------------------------------------------------------
    logic scl_fd;
    logic sda_fd;
    logic rise_d;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            scl_fd <= 1'b1;
            sda_fd <= 1'b1;
            rise_d <= 1'b0;
        end else begin
            scl_fd <= scl_f;
            sda_fd <= sda_f;
            rise_d <= scl_rise;
        end
    end

    assign start_det = scl_f & scl_fd & sda_fd & ~sda_f;
    assign stop_det  = scl_f & scl_fd & ~sda_fd & sda_f;
    assign scl_rise  = scl_f & ~scl_fd;
    assign scl_fall  = ~scl_f & scl_fd;

    // ------------------------------------------------------------------
    // Byte capture FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [3:0]          bit_cnt;
    logic [3:0]          bit_cnt_n;
    logic [7:0]          shift;
    logic [7:0]          shift_n;
    logic                dir_lat;
    logic                dir_lat_n;
    logic                start_flag;
    logic                start_flag_n;
    logic                bit0_high;
    logic                bit0_high_n;
    logic                wr_en;
    logic                wr_en_n;
    logic [CORE_W-1:0]   wr_rec;
    logic [CORE_W-1:0]   wr_rec_n;
    logic                abort_n;
    logic                partial;

    // Every STOP and repeated START is preceded by an SCL rise that samples
    // as bit 0. A START/STOP inside that same SCL-high phase is the bus
    // condition itself, not a truncated byte, so it must not abort.
    assign partial = (bit_cnt != 4'd0) && !((bit_cnt == 4'd1) && bit0_high);

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            dir_lat     <= 1'b0;
            start_flag  <= 1'b0;
            bit0_high   <= 1'b0;
            wr_en       <= 1'b0;
            wr_rec      <= '0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            dir_lat     <= dir_lat_n;
            start_flag  <= start_flag_n;
            bit0_high   <= bit0_high_n;
            wr_en       <= wr_en_n;
            wr_rec      <= wr_rec_n;
            abort_pulse <= abort_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        dir_lat_n    = dir_lat;
        start_flag_n = start_flag;
        bit0_high_n  = bit0_high;
        wr_en_n      = 1'b0;
        wr_rec_n     = wr_rec;
        abort_n      = 1'b0;

        if (start_det) begin
            state_n      = ST_BUSY;
            start_flag_n = 1'b1;
            bit_cnt_n    = 4'd0;
            bit0_high_n  = 1'b0;
            abort_n      = partial;
        end else if (stop_det) begin
            state_n      = ST_IDLE;
            start_flag_n = 1'b0;
            bit_cnt_n    = 4'd0;
            bit0_high_n  = 1'b0;
            abort_n      = partial;
        end else if ((state == ST_BUSY) && rise_d) begin
            if (bit_cnt == 4'd8) begin
                // ACK bit: SDA low means acknowledged.
                wr_en_n      = 1'b1;
                wr_rec_n     = {start_flag, dir_lat, ~sda_f, shift};
                start_flag_n = 1'b0;
                bit_cnt_n    = 4'd0;
            end else begin
                shift_n = {shift[6:0], sda_f};
                if (bit_cnt == 4'd0) begin
                    dir_lat_n   = dir_s;
                    bit0_high_n = 1'b1;
                end
                bit_cnt_n = bit_cnt + 4'd1;
            end
        end else if (scl_fall) begin
            bit0_high_n = 1'b0;
        end
    end

    assign bus_busy = (state == ST_BUSY);

    // ------------------------------------------------------------------
    // Optional free-running timestamp
    // ------------------------------------------------------------------
    logic [REC_W-1:0] push_rec;

`ifdef I2C_BYTE_CAPTURE_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= 16'h0000;
        end else begin
            ts_cnt <= ts_cnt + 16'h0001;
        end
    end

    assign push_rec = {ts_cnt, wr_rec};
`else
    assign push_rec = wr_rec;
`endif

    // ------------------------------------------------------------------
    // Record FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      level;
    logic             full;
    logic             pop;
    logic             push;
    logic             ovf_set;
    logic [REC_W-1:0] head;

    assign full    = (level == DEPTH_L);
    assign pop     = out_valid & out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push    = wr_en & (~full | pop);
    assign ovf_set = wr_en & full & ~pop;

    always_ff @(posedge system_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero while empty so the uninitialised array
    // never shows on the interface.
    assign out_valid = (level != '0);
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_ack   = out_valid & head[8];
    assign out_dir   = out_valid & head[9];
    assign out_start = out_valid & head[10];
`ifdef I2C_BYTE_CAPTURE_TIMESTAMP_EN
    assign out_ts    = out_valid ? head[REC_W-1:CORE_W] : 16'h0000;
`endif

endmodule
